// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: display timing, host port and RAM port bundle for the framebuffer arbiter.
interface vga_fb_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 15
);
   logic              p_tick;
   logic              video_on;
   logic [9:0]        pixel_x;
   logic [9:0]        pixel_y;
   logic              disp_en;
   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_ack;
   logic [DATA_W-1:0] host_rdata;
   logic              host_rvalid;
   logic              host_err;
   logic [DATA_W-1:0] pix_data;
   logic              pix_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   modport master (
      output p_tick, video_on, pixel_x, pixel_y, disp_en,
      output host_req, host_we, host_addr, host_wdata, mem_rdata,
      input  host_ack, host_rdata, host_rvalid, host_err, pix_data, pix_valid,
      input  mem_addr, mem_we, mem_wdata
   );
   modport slave (
      input  p_tick, video_on, pixel_x, pixel_y, disp_en,
      input  host_req, host_we, host_addr, host_wdata, mem_rdata,
      output host_ack, host_rdata, host_rvalid, host_err, pix_data, pix_valid,
      output mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between display fetch and a host port.
module vga_fb_arbiter #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int SHIFT  = 2,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 15
) (
   input  logic            clk,
   input  logic            reset,
   vga_fb_arbiter_if.slave bus
);
   localparam logic [31:0] FB_W     = 32'(H_RES >> SHIFT);
   localparam logic [31:0] FB_DEPTH = FB_W * 32'(V_RES >> SHIFT);
   localparam logic [1:0]  TAG_NONE = 2'd0;
   localparam logic [1:0]  TAG_DISP = 2'd1;
   localparam logic [1:0]  TAG_HOST = 2'd2;
   localparam logic [1:0]  TAG_BAD  = 2'd3;
   logic              disp_slot, host_slot, host_ok, host_go;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              host_ack_q, host_ack_d, host_err_q, host_err_d;
   logic [1:0]        tag1_q, tag1_d, tag2_q;
   logic              pix_valid_q, pix_valid_d, host_rvalid_q, host_rvalid_d;
   logic [DATA_W-1:0] pix_data_q, pix_data_d, host_rdata_q, host_rdata_d;
   always_comb begin
      disp_slot     = bus.disp_en & bus.p_tick & bus.video_on;
      host_slot     = ~disp_slot & bus.host_req & ~host_ack_q;
      host_ok       = 32'(bus.host_addr) < FB_DEPTH;
      host_go       = host_slot & host_ok;
      mem_addr_d    = disp_slot ? ADDR_W'(32'(bus.pixel_y >> SHIFT) * FB_W + 32'(bus.pixel_x >> SHIFT))
                    : host_go   ? bus.host_addr : mem_addr_q;
      mem_we_d      = host_go & bus.host_we;
      mem_wdata_d   = host_go ? bus.host_wdata : mem_wdata_q;
      host_ack_d    = host_slot;
      host_err_d    = host_slot & ~host_ok;
      // Each issued read carries a tag so its data, two cycles later, reaches the right consumer
      tag1_d        = disp_slot ? TAG_DISP
                    : (host_slot & ~bus.host_we) ? (host_ok ? TAG_HOST : TAG_BAD) : TAG_NONE;
      pix_valid_d   = tag2_q == TAG_DISP;
      host_rvalid_d = (tag2_q == TAG_HOST) | (tag2_q == TAG_BAD);
      pix_data_d    = (tag2_q == TAG_DISP) ? bus.mem_rdata : pix_data_q;
      host_rdata_d  = (tag2_q == TAG_HOST) ? bus.mem_rdata
                    : (tag2_q == TAG_BAD)  ? '0 : host_rdata_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_addr_q    <= '0;
         mem_we_q      <= 1'b0;
         mem_wdata_q   <= '0;
         host_ack_q    <= 1'b0;
         host_err_q    <= 1'b0;
         tag1_q        <= TAG_NONE;
         tag2_q        <= TAG_NONE;
         pix_valid_q   <= 1'b0;
         host_rvalid_q <= 1'b0;
         pix_data_q    <= '0;
         host_rdata_q  <= '0;
      end else begin
         mem_addr_q    <= mem_addr_d;
         mem_we_q      <= mem_we_d;
         mem_wdata_q   <= mem_wdata_d;
         host_ack_q    <= host_ack_d;
         host_err_q    <= host_err_d;
         tag1_q        <= tag1_d;
         tag2_q        <= tag1_q;
         pix_valid_q   <= pix_valid_d;
         host_rvalid_q <= host_rvalid_d;
         pix_data_q    <= pix_data_d;
         host_rdata_q  <= host_rdata_d;
      end
   end
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.host_ack    = host_ack_q;
   assign bus.host_err    = host_err_q;
   assign bus.host_rvalid = host_rvalid_q;
   assign bus.host_rdata  = host_rdata_q;
   assign bus.pix_valid   = pix_valid_q;
   assign bus.pix_data    = pix_data_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed and randomized checks of the framebuffer arbiter against
// a cycle-scheduled behavioural model with its own shadow copy of the framebuffer.
module tb_vga_fb_arbiter;
   localparam int DEPTH = 19200;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ram_init = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   always #5 clk = ~clk;
   vga_fb_arbiter_if #(.DATA_W(8), .ADDR_W(15)) bus ();
   vga_fb_arbiter #(.H_RES(640), .V_RES(480), .SHIFT(2), .DATA_W(8), .ADDR_W(15)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   function automatic logic [7:0] init_val(int i);
      return 8'(i * 37 + (i >> 7) + 11);
   endfunction
   logic [7:0] ram [0:32767];
   always @(posedge clk) begin
      if (ram_init) for (int i = 0; i < 32768; i++) ram[i] <= init_val(i);
      else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end
   // behavioural model: events scheduled by absolute cycle into a small ring
   logic [7:0]  shadow [0:32767];
   int          cyc = 0;
   int          last_grant = -10;
   logic        ev_ack [8], ev_err [8], ev_we [8], ev_pv [8], ev_hv [8], ev_as [8], ev_ws [8];
   logic [14:0] ev_addr [8];
   logic [7:0]  ev_wd [8], ev_pd [8], ev_hd [8];
   logic        x_ack, x_err, x_we, x_pv, x_hv;
   logic [14:0] x_addr;
   logic [7:0]  x_wd, x_pd, x_hd;
   task automatic clear_slot(int s);
      ev_ack[s] = 0; ev_err[s] = 0; ev_we[s] = 0; ev_pv[s] = 0; ev_hv[s] = 0;
      ev_as[s] = 0; ev_ws[s] = 0; ev_addr[s] = 0; ev_wd[s] = 0; ev_pd[s] = 0; ev_hd[s] = 0;
   endtask
   task automatic model_decide();
      int a, s1, s3;
      s1 = (cyc + 1) % 8;
      s3 = (cyc + 3) % 8;
      if (reset) begin
         for (int s = 0; s < 8; s++) clear_slot(s);
         last_grant = -10;
      end else if (bus.disp_en && bus.p_tick && bus.video_on) begin
         a = ((int'(bus.pixel_y) / 4) * 160 + int'(bus.pixel_x) / 4) % 32768;
         ev_as[s1] = 1; ev_addr[s1] = 15'(a);
         ev_pv[s3] = 1; ev_pd[s3] = shadow[a];
      end else if (bus.host_req && last_grant != cyc - 1) begin
         last_grant = cyc;
         ev_ack[s1] = 1;
         if (int'(bus.host_addr) < DEPTH) begin
            ev_as[s1] = 1; ev_addr[s1] = bus.host_addr;
            ev_ws[s1] = 1; ev_wd[s1] = bus.host_wdata; ev_we[s1] = bus.host_we;
            if (bus.host_we) shadow[bus.host_addr] = bus.host_wdata;
            else begin ev_hv[s3] = 1; ev_hd[s3] = shadow[bus.host_addr]; end
         end else begin
            ev_err[s1] = 1;
            if (!bus.host_we) begin ev_hv[s3] = 1; ev_hd[s3] = 8'h00; end
         end
      end
   endtask
   task automatic cycle();
      logic r;
      int s;
      r = reset;
      model_decide();
      @(posedge clk);
      #1;
      cyc++;
      s = cyc % 8;
      if (r) begin
         x_ack = 0; x_err = 0; x_we = 0; x_pv = 0; x_hv = 0;
         x_addr = 0; x_wd = 0; x_pd = 0; x_hd = 0;
      end else begin
         x_ack = ev_ack[s]; x_err = ev_err[s]; x_we = ev_we[s];
         x_pv = ev_pv[s]; x_hv = ev_hv[s];
         if (ev_as[s]) x_addr = ev_addr[s];
         if (ev_ws[s]) x_wd = ev_wd[s];
         if (ev_pv[s]) x_pd = ev_pd[s];
         if (ev_hv[s]) x_hd = ev_hd[s];
      end
      clear_slot(s);
   endtask
   function automatic logic [43:0] act_v();
      return {bus.host_ack, bus.host_err, bus.mem_we, bus.mem_addr, bus.mem_wdata,
              bus.pix_valid, bus.pix_data, bus.host_rvalid, bus.host_rdata};
   endfunction
   function automatic logic [43:0] exp_v();
      return {x_ack, x_err, x_we, x_addr, x_wd, x_pv, x_pd, x_hv, x_hd};
   endfunction
   task automatic idle();
      bus.p_tick = 0; bus.video_on = 0; bus.pixel_x = 0; bus.pixel_y = 0; bus.disp_en = 1;
      bus.host_req = 0; bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
   endtask
   task automatic test_reset();
      reset = 1; ram_init = 1; idle();
      cycle();
      ram_init = 0;
      cycle(); cycle();
      n_chk++;
      if (act_v() !== 44'd0) $display("FAIL reset_outputs got=%h want=0", act_v()); else n_pass++;
      reset = 0;
      bus.video_on = 1; bus.p_tick = 1; bus.pixel_x = 40; bus.pixel_y = 40;
      cycle();
      idle(); reset = 1;
      cycle(); cycle(); cycle();
      reset = 0;
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (bus.pix_valid !== 1'b0) $display("FAIL reset_flush pix_valid got=%b want=0", bus.pix_valid);
         else n_pass++;
         cycle();
      end
   endtask
   task automatic test_host_write();
      idle(); bus.host_req = 1; bus.host_we = 1; bus.host_addr = 5; bus.host_wdata = 8'hA5;
      cycle();
      n_chk++;
      if ({bus.host_ack, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 15'd5, 8'hA5})
         $display("FAIL host_write_grant got ack=%b we=%b addr=%0d wd=%h want 1 1 5 a5",
                  bus.host_ack, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      else n_pass++;
      cycle();
      n_chk++;
      if ({bus.host_ack, bus.mem_we} !== 2'b00)
         $display("FAIL host_write_no_double got ack=%b we=%b want 0 0", bus.host_ack, bus.mem_we);
      else n_pass++;
      idle();
      n_chk++;
      if (ram[5] !== 8'hA5) $display("FAIL host_write_ram got=%h want=a5", ram[5]); else n_pass++;
      cycle();
   endtask
   task automatic test_display();
      idle(); bus.host_req = 1; bus.host_we = 1; bus.host_addr = 162; bus.host_wdata = 8'h3C;
      cycle();
      idle(); cycle();
      bus.video_on = 1; bus.p_tick = 1; bus.pixel_x = 8; bus.pixel_y = 4;
      cycle();
      n_chk++;
      if ({bus.mem_addr, bus.mem_we} !== {15'd162, 1'b0})
         $display("FAIL disp_addr got addr=%0d we=%b want 162 0", bus.mem_addr, bus.mem_we);
      else n_pass++;
      idle(); cycle();
      n_chk++;
      if (bus.pix_valid !== 1'b0) $display("FAIL disp_early got pix_valid=%b want 0", bus.pix_valid);
      else n_pass++;
      cycle();
      n_chk++;
      if ({bus.pix_valid, bus.pix_data} !== {1'b1, 8'h3C})
         $display("FAIL disp_data got v=%b d=%h want 1 3c", bus.pix_valid, bus.pix_data);
      else n_pass++;
      cycle();
      n_chk++;
      if ({bus.pix_valid, bus.pix_data} !== {1'b0, 8'h3C})
         $display("FAIL disp_hold got v=%b d=%h want 0 3c", bus.pix_valid, bus.pix_data);
      else n_pass++;
   endtask
   task automatic test_priority();
      idle(); cycle();
      bus.host_req = 1; bus.host_we = 0; bus.host_addr = 7;
      bus.video_on = 1; bus.p_tick = 1; bus.pixel_x = 20; bus.pixel_y = 12;
      cycle();
      n_chk++;
      if ({bus.host_ack, bus.mem_addr} !== {1'b0, 15'd485})
         $display("FAIL prio_display got ack=%b addr=%0d want 0 485", bus.host_ack, bus.mem_addr);
      else n_pass++;
      bus.p_tick = 0;
      cycle();
      n_chk++;
      if ({bus.host_ack, bus.mem_addr, bus.mem_we} !== {1'b1, 15'd7, 1'b0})
         $display("FAIL prio_host_grant got ack=%b addr=%0d we=%b want 1 7 0",
                  bus.host_ack, bus.mem_addr, bus.mem_we);
      else n_pass++;
      idle(); cycle();
      n_chk++;
      if ({bus.pix_valid, bus.pix_data, bus.host_rvalid} !== {1'b1, init_val(485), 1'b0})
         $display("FAIL prio_pix got v=%b d=%h hv=%b want 1 %h 0",
                  bus.pix_valid, bus.pix_data, bus.host_rvalid, init_val(485));
      else n_pass++;
      cycle();
      n_chk++;
      if ({bus.host_rvalid, bus.host_rdata} !== {1'b1, init_val(7)})
         $display("FAIL prio_host_read got v=%b d=%h want 1 %h", bus.host_rvalid, bus.host_rdata, init_val(7));
      else n_pass++;
   endtask
   task automatic test_bad_addr();
      idle(); cycle();
      bus.host_req = 1; bus.host_we = 1; bus.host_addr = 15'd19200; bus.host_wdata = 8'hFF;
      cycle();
      n_chk++;
      if ({bus.host_ack, bus.host_err, bus.mem_we} !== 3'b110)
         $display("FAIL bad_write got ack=%b err=%b we=%b want 1 1 0", bus.host_ack, bus.host_err, bus.mem_we);
      else n_pass++;
      idle(); cycle();
      n_chk++;
      if ({bus.host_err, bus.mem_we} !== 2'b00)
         $display("FAIL bad_write_after got err=%b we=%b want 0 0", bus.host_err, bus.mem_we);
      else n_pass++;
      bus.host_req = 1; bus.host_we = 0; bus.host_addr = 15'd19199;
      cycle();
      n_chk++;
      if ({bus.host_ack, bus.host_err, bus.mem_addr} !== {2'b10, 15'd19199})
         $display("FAIL edge_read_grant got ack=%b err=%b addr=%0d want 1 0 19199",
                  bus.host_ack, bus.host_err, bus.mem_addr);
      else n_pass++;
      idle(); cycle(); cycle();
      n_chk++;
      if ({bus.host_rvalid, bus.host_rdata} !== {1'b1, init_val(19199)})
         $display("FAIL edge_read_data got v=%b d=%h want 1 %h", bus.host_rvalid, bus.host_rdata, init_val(19199));
      else n_pass++;
      bus.host_req = 1; bus.host_we = 0; bus.host_addr = 15'd20000;
      cycle();
      n_chk++;
      if ({bus.host_ack, bus.host_err} !== 2'b11)
         $display("FAIL bad_read_grant got ack=%b err=%b want 1 1", bus.host_ack, bus.host_err);
      else n_pass++;
      idle(); cycle(); cycle();
      n_chk++;
      if ({bus.host_rvalid, bus.host_rdata} !== {1'b1, 8'h00})
         $display("FAIL bad_read_data got v=%b d=%h want 1 00", bus.host_rvalid, bus.host_rdata);
      else n_pass++;
   endtask
   task automatic test_disp_disable();
      idle(); cycle();
      bus.disp_en = 0; bus.video_on = 1; bus.p_tick = 1; bus.host_req = 1; bus.host_addr = 9;
      cycle();
      n_chk++;
      if ({bus.host_ack, bus.mem_addr} !== {1'b1, 15'd9})
         $display("FAIL disable_host_slot got ack=%b addr=%0d want 1 9", bus.host_ack, bus.mem_addr);
      else n_pass++;
      idle(); cycle(); cycle(); cycle();
      bus.video_on = 1; bus.p_tick = 1; bus.pixel_x = 4; bus.pixel_y = 0;
      cycle();
      bus.disp_en = 0;
      cycle(); cycle();
      n_chk++;
      if ({bus.pix_valid, bus.pix_data} !== {1'b1, init_val(1)})
         $display("FAIL disable_inflight got v=%b d=%h want 1 %h", bus.pix_valid, bus.pix_data, init_val(1));
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_chk++;
         if ({bus.pix_valid, bus.mem_we} !== 2'b00)
            $display("FAIL disable_no_fetch got v=%b we=%b want 0 0", bus.pix_valid, bus.mem_we);
         else n_pass++;
      end
      idle();
   endtask
   task automatic test_full_line();
      int acks = 0;
      idle(); cycle(); cycle();
      for (int y = 118; y < 120; y++)
         for (int x = 0; x < 800; x++)
            for (int ph = 0; ph < 2; ph++) begin
               bus.p_tick = (ph == 0); bus.video_on = (x < 640);
               bus.pixel_x = 10'(x); bus.pixel_y = 10'(y);
               bus.host_req = 1; bus.host_we = 1'($urandom_range(0, 1));
               bus.host_addr = 15'($urandom_range(0, 19500)); bus.host_wdata = 8'($urandom);
               cycle();
               acks += int'(bus.host_ack);
               n_chk++;
               if (act_v() !== exp_v()) $display("FAIL line_model cyc=%0d got=%h want=%h", cyc, act_v(), exp_v());
               else n_pass++;
            end
      n_chk++;
      if (acks != 1600) $display("FAIL line_host_slots got=%0d want=1600", acks); else n_pass++;
      idle();
   endtask
   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         bus.disp_en = ($urandom_range(0, 9) != 0);
         bus.p_tick = 1'($urandom_range(0, 1)); bus.video_on = 1'($urandom_range(0, 1));
         bus.pixel_x = 10'($urandom_range(0, 799)); bus.pixel_y = 10'($urandom_range(0, 524));
         bus.host_req = ($urandom_range(0, 9) < 7); bus.host_we = 1'($urandom_range(0, 1));
         bus.host_addr = 15'($urandom_range(0, 20479)); bus.host_wdata = 8'($urandom);
         cycle();
         n_chk++;
         if (act_v() !== exp_v()) $display("FAIL rand_model cyc=%0d got=%h want=%h", cyc, act_v(), exp_v());
         else n_pass++;
      end
      reset = 0; idle();
   endtask
   initial begin
      for (int i = 0; i < 32768; i++) shadow[i] = init_val(i);
      idle();
      test_reset();
      test_host_write();
      test_display();
      test_priority();
      test_bad_addr();
      test_disp_disable();
      test_full_line();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
